// File: rtl/sar_adc_scan_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC scanner.
package sar_adc_scan_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DEF_DAC_SETTLE = 512;
  localparam int unsigned DEF_MUX_SETTLE = 16;
  localparam int unsigned MAX_CHANNELS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUX     = 3'd1,
    ST_TRIAL   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } adc_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } chan_pick_t;

  // Lowest enabled channel whose index is >= first.
  function automatic chan_pick_t next_chan(input logic [7:0] mask, input logic [3:0] first);
    chan_pick_t pick;
    pick = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= first)) begin
        pick.found = 1'b1;
        pick.idx   = 3'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sar_adc_scan_sd_dac.sv
// First-order sigma-delta DAC: the accumulator carry-out is the bitstream.
module sd_dac #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             CLK,
  input  logic             nReset,
  input  logic [WIDTH-1:0] DACin,
  output logic             DACout
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, DACin};

  // Accumulate the input code; each overflow emits a one.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      acc    <= '0;
      DACout <= 1'b0;
    end else begin
      acc    <= sum[WIDTH-1:0];
      DACout <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/sar_adc_scan.sv
// Multi-channel successive-approximation ADC scanner.
// Optional feature: define ADC_OVERSAMPLE_EN to average four conversions per channel.
module sar_adc_scan
  import sar_adc_scan_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned DAC_SETTLE = DEF_DAC_SETTLE,
  parameter int unsigned MUX_SETTLE = DEF_MUX_SETTLE,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                nReset,
  input  logic                Start,
  input  logic [CHANNELS-1:0] ChanEn,
  input  logic                gtRef,
  output logic [CH_W-1:0]     ChanSel,
  output logic                DACout,
  output logic                Busy,
  output logic [WIDTH-1:0]    Result,
  output logic [CH_W-1:0]     ResultChan,
  output logic                ResultValid
);

  localparam int unsigned SETTLE_MAX = (DAC_SETTLE > MUX_SETTLE) ? DAC_SETTLE : MUX_SETTLE;
  localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);
  localparam int unsigned BIT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] REF_MSB = WIDTH'(1) << (WIDTH - 1);

  adc_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [WIDTH-1:0]    reference;
  logic [CHANNELS-1:0] mask_q;
  logic [WIDTH-1:0]    bit_mask;
  logic [WIDTH-1:0]    kept_ref;
  logic [WIDTH-1:0]    done_code;
  logic                last_conv;
  chan_pick_t          first_pick;
  chan_pick_t          next_pick;

  assign bit_mask   = WIDTH'(1) << bit_idx;
  assign kept_ref   = gtRef ? reference : (reference & ~bit_mask);
  assign first_pick = next_chan(8'(ChanEn), 4'd0);
  assign next_pick  = next_chan(8'(mask_q), 4'(ChanSel) + 4'd1);

`ifdef ADC_OVERSAMPLE_EN
  localparam int unsigned ACC_W = WIDTH + 2;
  logic [1:0]       conv_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum   = acc + ACC_W'(reference);
  assign done_code = acc_sum[ACC_W-1:2];
  assign last_conv = (conv_cnt == 2'd3);

  // Sum four back-to-back codes for the current channel.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      conv_cnt <= '0;
      acc      <= '0;
    end else if (state == ST_DONE) begin
      if (last_conv) begin
        conv_cnt <= '0;
        acc      <= '0;
      end else begin
        conv_cnt <= conv_cnt + 2'd1;
        acc      <= acc_sum;
      end
    end
  end
`else
  assign done_code = reference;
  assign last_conv = 1'b1;
`endif

  // Half-LSB offset: the DAC sees the code with a forced 1 appended.
  sd_dac #(.WIDTH(WIDTH + 1)) u_dac (
    .CLK    (CLK),
    .nReset (nReset),
    .DACin  ({reference, 1'b1}),
    .DACout (DACout)
  );

  // Scan sequencer: channel select, settle timing and bit-by-bit search.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      reference   <= '0;
      mask_q      <= '0;
      ChanSel     <= '0;
      Busy        <= 1'b0;
      Result      <= '0;
      ResultChan  <= '0;
      ResultValid <= 1'b0;
    end else begin
      ResultValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && (|ChanEn)) begin
            mask_q    <= ChanEn;
            ChanSel   <= CH_W'(first_pick.idx);
            Busy      <= 1'b1;
            reference <= '0;
            cnt       <= '0;
            state     <= ST_MUX;
          end
        end
        ST_MUX: begin
          if (cnt == CNT_W'(MUX_SETTLE - 1)) begin
            cnt       <= '0;
            bit_idx   <= BIT_W'(WIDTH - 1);
            reference <= REF_MSB;
            state     <= ST_TRIAL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_TRIAL: begin
          if (cnt == CNT_W'(DAC_SETTLE - 1)) begin
            cnt   <= '0;
            state <= ST_COMPARE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_COMPARE: begin
          if (bit_idx == '0) begin
            reference <= kept_ref;
            state     <= ST_DONE;
          end else begin
            reference <= kept_ref | (bit_mask >> 1);
            bit_idx   <= bit_idx - BIT_W'(1);
            state     <= ST_TRIAL;
          end
        end
        ST_DONE: begin
          if (!last_conv) begin
            reference <= REF_MSB;
            bit_idx   <= BIT_W'(WIDTH - 1);
            cnt       <= '0;
            state     <= ST_TRIAL;
          end else begin
            Result      <= done_code;
            ResultChan  <= ChanSel;
            ResultValid <= 1'b1;
            if (next_pick.found) begin
              ChanSel   <= CH_W'(next_pick.idx);
              reference <= '0;
              cnt       <= '0;
              state     <= ST_MUX;
            end else begin
              Busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
